// File: rtl/data_ram_responder_pkg.sv
// Shared types and helpers for the data-port RAM responder.
// Optional feature macro: DATA_RAM_INIT_CLEAR_EN (post-reset clearing sweep).
package data_ram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } ram_state_t;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  be_t;

   // Replace the byte lanes of old_word selected by be with those of new_word.
   function automatic word_t merge_bytes(input word_t old_word, input word_t new_word, input be_t be);
      word_t res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// CPU data-port bus between mips_cpu_harvard (master) and the RAM responder (slave).
// Handshake: there is no stall; a store is taken on any enabled posedge where the
// responder is ready and the address hits, and load data is valid combinationally
// in the same cycle as data_read.
interface data_ram_responder_if;
   import data_ram_pkg::*;

   logic [31:0] data_address;
   logic        data_write;
   logic        data_read;
   be_t         data_byteenable;
   word_t       data_writedata;
   word_t       data_readdata;

   modport master (
      output data_address, data_write, data_read, data_byteenable, data_writedata,
      input  data_readdata
   );

   modport slave (
      input  data_address, data_write, data_read, data_byteenable, data_writedata,
      output data_readdata
   );
endinterface

// File: rtl/data_ram_responder_wbuf.sv
// One-entry posted write buffer: captures accepted stores, strobes the commit of
// the held entry into the array on the following enabled edge, and merges the held
// bytes into load data when the load targets the buffered word.
module data_ram_wbuf
   import data_ram_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              load,
   input  logic [ADDR_W-1:0] ld_idx,
   input  be_t               ld_be,
   input  word_t             ld_data,
   input  logic [ADDR_W-1:0] rd_idx,
   input  word_t             rd_word,
   output word_t             fwd_word,
   output logic              commit,
   output logic [ADDR_W-1:0] wb_idx,
   output be_t               wb_be,
   output word_t             wb_data
);

   logic wb_valid;

   // Capture a new store, or drain the entry once it has been committed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid <= 1'b0;
         wb_idx   <= '0;
         wb_be    <= '0;
         wb_data  <= '0;
      end else if (clk_enable) begin
         if (load) begin
            wb_valid <= 1'b1;
            wb_idx   <= ld_idx;
            wb_be    <= ld_be;
            wb_data  <= ld_data;
         end else begin
            wb_valid <= 1'b0;
         end
      end
   end

   // The held entry lands in the array on every enabled edge it is valid,
   // independent of whether a new store replaces it on that same edge.
   assign commit = wb_valid & clk_enable;

   // Forward buffered lanes over the array word for a matching load.
   always_comb begin
      fwd_word = rd_word;
      if (wb_valid && (wb_idx == rd_idx)) fwd_word = merge_bytes(rd_word, wb_data, wb_be);
   end

endmodule

// File: rtl/data_ram_responder.sv
// Data-port RAM responder for the Harvard MIPS core: word array with byte enables,
// posted write buffer with forwarding, INIT/RUN FSM and sticky out-of-range flag.
// Optional feature macro: DATA_RAM_INIT_CLEAR_EN -- when defined, INIT zeroes every
// word before RUN; otherwise INIT lasts one enabled edge and contents start undefined.
module data_ram_responder
   import data_ram_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clk_enable,
   data_ram_responder_if.slave bus,
   output logic                ready,
   output logic                range_err,
   output ram_state_t          state_dbg
);

   localparam int DEPTH = 1 << ADDR_W;

   ram_state_t        state, state_nxt;
   word_t             mem [DEPTH];
   logic              hit;
   logic [ADDR_W-1:0] idx;
   logic              accept;
   word_t             fwd_word;
   logic              commit;
   logic [ADDR_W-1:0] wb_idx;
   be_t               wb_be;
   word_t             wb_data;
   logic              unused_addr_lsb;

   assign hit             = (bus.data_address[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign idx             = bus.data_address[ADDR_W+1:2];
   assign unused_addr_lsb = ^bus.data_address[1:0];
   assign accept          = clk_enable & ready & bus.data_write & hit;

`ifdef DATA_RAM_INIT_CLEAR_EN
   logic [ADDR_W-1:0] clr_cnt;

   // Sweep pointer for the post-reset clear; only advances on enabled INIT edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          clr_cnt <= '0;
      else if (clk_enable && state == INIT) clr_cnt <= clr_cnt + 1'b1;
   end
`endif

   // FSM state register; a disabled clock freezes it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          state <= INIT;
      else if (clk_enable) state <= state_nxt;
   end

   // FSM next state: leave INIT once the sweep (if any) has cleared the last word.
   always_comb begin
      state_nxt = state;
`ifdef DATA_RAM_INIT_CLEAR_EN
      if (state == INIT && clr_cnt == {ADDR_W{1'b1}}) state_nxt = RUN;
`else
      if (state == INIT) state_nxt = RUN;
`endif
   end

   // FSM outputs.
   always_comb begin
      ready     = (state == RUN);
      state_dbg = state;
   end

   // Array writes: clearing sweep during INIT, buffered-store commit during RUN.
   always_ff @(posedge clk) begin
`ifdef DATA_RAM_INIT_CLEAR_EN
      if (clk_enable && state == INIT) mem[clr_cnt] <= '0;
      else if (commit)                 mem[wb_idx] <= merge_bytes(mem[wb_idx], wb_data, wb_be);
`else
      if (commit) mem[wb_idx] <= merge_bytes(mem[wb_idx], wb_data, wb_be);
`endif
   end

   // Sticky flag for any request that falls outside the window while ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) range_err <= 1'b0;
      else if (clk_enable && ready && (bus.data_read || bus.data_write) && !hit) range_err <= 1'b1;
   end

   data_ram_wbuf #(
      .ADDR_W(ADDR_W)
   ) u_wbuf (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .load       (accept),
      .ld_idx     (idx),
      .ld_be      (bus.data_byteenable),
      .ld_data    (bus.data_writedata),
      .rd_idx     (idx),
      .rd_word    (mem[idx]),
      .fwd_word   (fwd_word),
      .commit     (commit),
      .wb_idx     (wb_idx),
      .wb_be      (wb_be),
      .wb_data    (wb_data)
   );

   // Load data is pre-store contents plus forwarding, gated to zero when not serving.
   assign bus.data_readdata = (bus.data_read && hit && ready) ? fwd_word : '0;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder (ADDR_W=8, BASE_ADDR=0); covers both
// builds of DATA_RAM_INIT_CLEAR_EN.
module tb_data_ram_responder;
   import data_ram_pkg::*;

   logic       clk;
   logic       reset;
   logic       clk_enable;
   logic       ready;
   logic       range_err;
   ram_state_t state_dbg;
   int         n_vec;
   int         n_miss;

   data_ram_responder_if bus();

   data_ram_responder #(
      .ADDR_W    (8),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .bus        (bus),
      .ready      (ready),
      .range_err  (range_err),
      .state_dbg  (state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      bus.data_write = 1'b0;
      bus.data_read  = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      bus.data_read       = 1'b0;
      bus.data_write      = 1'b1;
      bus.data_address    = addr;
      bus.data_writedata  = data;
      bus.data_byteenable = be;
      tick();
      bus.data_write = 1'b0;
   endtask

   task automatic read_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      bus.data_write   = 1'b0;
      bus.data_read    = 1'b1;
      bus.data_address = addr;
      #2;
      check_eq(tag, bus.data_readdata, exp);
   endtask

   initial begin
      n_vec               = 0;
      n_miss              = 0;
      reset               = 1'b0;
      clk_enable          = 1'b1;
      bus.data_address    = 32'h40;
      bus.data_write      = 1'b0;
      bus.data_read       = 1'b1;
      bus.data_byteenable = 4'h0;
      bus.data_writedata  = 32'h0;

      // reset values while held in reset, with a read request pending
      #12;
      check_eq("rst_readdata", bus.data_readdata, 32'h0);
      check_eq("rst_ready", {31'b0, ready}, 32'h0);
      check_eq("rst_range_err", {31'b0, range_err}, 32'h0);
      tick();
      reset = 1'b1;
      go_idle();

`ifdef DATA_RAM_INIT_CLEAR_EN
      // first sweep interrupted by reset at count 100
      repeat (100) tick();
      check_eq("ready_at_100", {31'b0, ready}, 32'h0);
      reset = 1'b0;
      #2;
      check_eq("ready_in_reset", {31'b0, ready}, 32'h0);
      tick();
      reset = 1'b1;
      // restarted sweep with a 10-cycle clock-enable pause in the middle
      repeat (100) tick();
      clk_enable = 1'b0;
      repeat (10) tick();
      clk_enable = 1'b1;
      repeat (155) tick();
      check_eq("ready_after_255", {31'b0, ready}, 32'h0);
      tick();
      check_eq("ready_after_256", {31'b0, ready}, 32'h1);
      read_chk(32'h40, 32'h0, "cleared_0x40");
      read_chk(32'h3FC, 32'h0, "cleared_top");
`else
      check_eq("ready_before_1", {31'b0, ready}, 32'h0);
      tick();
      check_eq("ready_after_1", {31'b0, ready}, 32'h1);
`endif
      go_idle();

      // known content for word 0 (used by the dropped-store check)
      do_store(32'h0, 32'h1234_5678, 4'hF);

      // full-word store: forwarded next cycle, committed later
      do_store(32'h10, 32'hDEAD_BEEF, 4'hF);
      read_chk(32'h10, 32'hDEAD_BEEF, "fwd_0x10");
      go_idle();
      repeat (5) tick();
      read_chk(32'h10, 32'hDEAD_BEEF, "commit_0x10");
      bus.data_read = 1'b0;
      #2;
      check_eq("no_read_zero", bus.data_readdata, 32'h0);

      // partial-lane store over a full word
      do_store(32'h20, 32'hAAAA_AAAA, 4'hF);
      do_store(32'h20, 32'h1122_3344, 4'b0101);
      read_chk(32'h20, 32'hAA22_AA44, "merge_fwd_0x20");
      go_idle();
      repeat (3) tick();
      read_chk(32'h20, 32'hAA22_AA44, "merge_commit_0x20");

      // back-to-back stores, same word then neighbour
      do_store(32'h30, 32'h1, 4'hF);
      do_store(32'h30, 32'h2, 4'hF);
      do_store(32'h34, 32'h3, 4'hF);
      read_chk(32'h30, 32'h2, "b2b_0x30");
      read_chk(32'h34, 32'h3, "b2b_0x34");

      // simultaneous read+write: old value now, new value next cycle
      bus.data_read       = 1'b1;
      bus.data_write      = 1'b1;
      bus.data_address    = 32'h30;
      bus.data_writedata  = 32'h9;
      bus.data_byteenable = 4'hF;
      #2;
      check_eq("rbw_same_cycle", bus.data_readdata, 32'h2);
      tick();
      read_chk(32'h30, 32'h9, "rbw_next_cycle");
      go_idle();

      // out-of-window access
      check_eq("range_err_clear", {31'b0, range_err}, 32'h0);
      read_chk(32'h400, 32'h0, "miss_readdata");
      tick();
      check_eq("range_err_set", {31'b0, range_err}, 32'h1);
      do_store(32'h400, 32'h55, 4'hF);
      go_idle();
      repeat (3) tick();
      read_chk(32'h0, 32'h1234_5678, "miss_store_dropped");
      check_eq("range_err_sticky", {31'b0, range_err}, 32'h1);

      // clock enable low: a pending store holds, a new store is ignored
      do_store(32'h50, 32'hCAFE_F00D, 4'hF);
      clk_enable          = 1'b0;
      bus.data_write      = 1'b1;
      bus.data_address    = 32'h50;
      bus.data_writedata  = 32'h0BAD_BEEF;
      bus.data_byteenable = 4'hF;
      repeat (10) tick();
      bus.data_write = 1'b0;
      clk_enable     = 1'b1;
      read_chk(32'h50, 32'hCAFE_F00D, "ce_low_store_ignored");
      go_idle();
      repeat (2) tick();
      read_chk(32'h50, 32'hCAFE_F00D, "ce_low_then_commit");
      go_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
